systolic_ctrl: RTL

Sequencer for the 2x2 systolic array. Accepts one matmul command (2x2 weight tile, active column count, row count), then runs the array through its phases: configure column enables, preload weights column-wise, pulse switch, stream skewed input rows, and drain results. Sits between the unified-buffer/host command path and the systolic array. Returns de-skewed result rows on a valid-only output port.

---
 rtl/systolic_ctrl.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for a 2x2 weight-stationary systolic array.
// Takes one matmul command at a time, then runs the array through its phases:
// column configure, two-cycle weight preload, switch, skewed row streaming,
// flush and drain. De-skewed result rows come out on res_*.
// Ports:
//   cmd_*          command handshake, weight tile, column count, row count
//   in_*           input row handshake and data
//   sys_*_in, ub_* drive toward the array and its column-enable logic
//   sys_*_out      array results and valids
//   res_*          de-skewed result rows (valid only)
//   busy/done/err_timeout  status
`default_nettype none

module systolic_ctrl #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ROW_CNT_W = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_col_size,
  input  logic [ROW_CNT_W-1:0] cmd_num_rows,
  input  logic [DATA_W-1:0]    cmd_w11,
  input  logic [DATA_W-1:0]    cmd_w12,
  input  logic [DATA_W-1:0]    cmd_w21,
  input  logic [DATA_W-1:0]    cmd_w22,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data_1,
  input  logic [DATA_W-1:0]    in_data_2,
  output logic [DATA_W-1:0]    sys_data_in_1x,
  output logic [DATA_W-1:0]    sys_data_in_2x,
  output logic                 sys_start,
  output logic [DATA_W-1:0]    sys_weight_in_x1,
  output logic [DATA_W-1:0]    sys_weight_in_x2,
  output logic                 sys_accept_w_1,
  output logic                 sys_accept_w_2,
  output logic                 sys_switch_in,
  output logic [15:0]          ub_rd_col_size_in,
  output logic                 ub_rd_col_size_valid_in,
  input  logic [DATA_W-1:0]    sys_data_out_x1,
  input  logic [DATA_W-1:0]    sys_data_out_x2,
  input  logic                 sys_valid_out_x1,
  input  logic                 sys_valid_out_x2,
  output logic                 res_valid,
  output logic [DATA_W-1:0]    res_data_1,
  output logic [DATA_W-1:0]    res_data_2,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CFG     = 4'd1;
  localparam logic [3:0] S_LOAD_W0 = 4'd2;
  localparam logic [3:0] S_LOAD_W1 = 4'd3;
  localparam logic [3:0] S_SWITCH  = 4'd4;
  localparam logic [3:0] S_STREAM  = 4'd5;
  localparam logic [3:0] S_FLUSH   = 4'd6;
  localparam logic [3:0] S_DRAIN   = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  // Control / command registers
  logic [3:0]           state_q, state_d;
  logic                 col2_q, col2_d;
  logic [ROW_CNT_W-1:0] n_rows_q, n_rows_d;
  logic [DATA_W-1:0]    w11_q, w11_d, w12_q, w12_d, w21_q, w21_d, w22_q, w22_d;
  logic [ROW_CNT_W-1:0] rows_fed_q, rows_fed_d, rows_out_q, rows_out_d;
  logic [DATA_W-1:0]    skew_q, skew_d, hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic [WD_W-1:0]      wdog_q, wdog_d;
  logic                 err_q, err_d;

  // Output registers
  logic                 cmd_ready_q, cmd_ready_d, in_ready_q, in_ready_d;
  logic [DATA_W-1:0]    d1x_q, d1x_d, d2x_q, d2x_d;
  logic                 start_q, start_d;
  logic [DATA_W-1:0]    wx1_q, wx1_d, wx2_q, wx2_d;
  logic                 acc1_q, acc1_d, acc2_q, acc2_d, sw_q, sw_d;
  logic [1:0]           ub_size_q, ub_size_d;
  logic                 ub_vld_q, ub_vld_d;
  logic                 res_valid_q, res_valid_d;
  logic [DATA_W-1:0]    res1_q, res1_d, res2_q, res2_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic accept, active, timeout;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    col2_d      = col2_q;
    n_rows_d    = n_rows_q;
    w11_d       = w11_q;
    w12_d       = w12_q;
    w21_d       = w21_q;
    w22_d       = w22_q;
    rows_fed_d  = rows_fed_q;
    rows_out_d  = rows_out_q;
    skew_d      = skew_q;
    hold_d      = hold_q;
    hold_vld_d  = 1'b0;
    wdog_d      = wdog_q;
    err_d       = err_q;
    d1x_d       = '0;
    d2x_d       = '0;
    start_d     = 1'b0;
    res_valid_d = 1'b0;
    res1_d      = '0;
    res2_d      = '0;
    timeout     = 1'b0;

    accept = in_valid && in_ready_q;
    active = (state_q == S_STREAM) || (state_q == S_FLUSH) || (state_q == S_DRAIN);

    // Row 2 lags row 1 by one cycle through the skew register
    if ((state_q == S_STREAM) || (state_q == S_FLUSH)) begin
      d2x_d   = skew_q;
      skew_d  = accept ? in_data_2 : '0;
      d1x_d   = accept ? in_data_1 : '0;
      start_d = accept;
      if (accept) rows_fed_d = rows_fed_q + ROW_CNT_W'(1);
    end

    // Column-2 result arrives one cycle after column 1: hold column 1, pair next cycle
    if (active) begin
      if (sys_valid_out_x1) begin
        hold_d     = sys_data_out_x1;
        hold_vld_d = 1'b1;
        wdog_d     = '0;
      end else begin
        wdog_d = wdog_q + WD_W'(1);
        if (wdog_d == WD_W'(TIMEOUT)) timeout = 1'b1;
      end
      if (hold_vld_q) begin
        res_valid_d = 1'b1;
        res1_d      = hold_q;
        res2_d      = (col2_q && sys_valid_out_x2) ? sys_data_out_x2 : '0;
        rows_out_d  = rows_out_q + ROW_CNT_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          col2_d     = (cmd_col_size != 2'd1);
          n_rows_d   = cmd_num_rows;
          w11_d      = cmd_w11;
          w12_d      = cmd_w12;
          w21_d      = cmd_w21;
          w22_d      = cmd_w22;
          rows_fed_d = '0;
          rows_out_d = '0;
          skew_d     = '0;
          hold_d     = '0;
          wdog_d     = '0;
          err_d      = 1'b0;
          state_d    = S_CFG;
        end
      end
      S_CFG:     state_d = S_LOAD_W0;
      S_LOAD_W0: state_d = S_LOAD_W1;
      S_LOAD_W1: state_d = S_SWITCH;
      S_SWITCH:  state_d = (n_rows_q == '0) ? S_DONE : S_STREAM;
      S_STREAM:  if (rows_fed_d == n_rows_q) state_d = S_FLUSH;
      S_FLUSH:   state_d = S_DRAIN;
      S_DRAIN:   if (rows_out_q == n_rows_q) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (timeout) begin
      err_d   = 1'b1;
      state_d = S_DONE;
    end

    // Phase outputs follow the next state so they line up with the state register
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    sw_d        = (state_d == S_SWITCH);
    ub_vld_d    = (state_d == S_CFG);
    ub_size_d   = (state_d == S_CFG) ? (col2_d ? 2'd2 : 2'd1) : 2'd0;
    in_ready_d  = (state_d == S_STREAM) && (rows_fed_d < n_rows_d);
    wx1_d       = '0;
    wx2_d       = '0;
    acc1_d      = 1'b0;
    acc2_d      = 1'b0;
    // Bottom weight row is pushed first so it ends up in the lower PE
    if (state_d == S_LOAD_W0) begin
      wx1_d  = w21_d;
      wx2_d  = col2_d ? w22_d : '0;
      acc1_d = 1'b1;
      acc2_d = col2_d;
    end else if (state_d == S_LOAD_W1) begin
      wx1_d  = w11_d;
      wx2_d  = col2_d ? w12_d : '0;
      acc1_d = 1'b1;
      acc2_d = col2_d;
    end
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col2_q      <= 1'b0;
      n_rows_q    <= '0;
      w11_q       <= '0;
      w12_q       <= '0;
      w21_q       <= '0;
      w22_q       <= '0;
      rows_fed_q  <= '0;
      rows_out_q  <= '0;
      skew_q      <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      d1x_q       <= '0;
      d2x_q       <= '0;
      start_q     <= 1'b0;
      wx1_q       <= '0;
      wx2_q       <= '0;
      acc1_q      <= 1'b0;
      acc2_q      <= 1'b0;
      sw_q        <= 1'b0;
      ub_size_q   <= '0;
      ub_vld_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res1_q      <= '0;
      res2_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col2_q      <= col2_d;
      n_rows_q    <= n_rows_d;
      w11_q       <= w11_d;
      w12_q       <= w12_d;
      w21_q       <= w21_d;
      w22_q       <= w22_d;
      rows_fed_q  <= rows_fed_d;
      rows_out_q  <= rows_out_d;
      skew_q      <= skew_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      in_ready_q  <= in_ready_d;
      d1x_q       <= d1x_d;
      d2x_q       <= d2x_d;
      start_q     <= start_d;
      wx1_q       <= wx1_d;
      wx2_q       <= wx2_d;
      acc1_q      <= acc1_d;
      acc2_q      <= acc2_d;
      sw_q        <= sw_d;
      ub_size_q   <= ub_size_d;
      ub_vld_q    <= ub_vld_d;
      res_valid_q <= res_valid_d;
      res1_q      <= res1_d;
      res2_q      <= res2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready               = cmd_ready_q;
  assign in_ready                = in_ready_q;
  assign sys_data_in_1x          = d1x_q;
  assign sys_data_in_2x          = d2x_q;
  assign sys_start               = start_q;
  assign sys_weight_in_x1        = wx1_q;
  assign sys_weight_in_x2        = wx2_q;
  assign sys_accept_w_1          = acc1_q;
  assign sys_accept_w_2          = acc2_q;
  assign sys_switch_in           = sw_q;
  assign ub_rd_col_size_in       = 16'(ub_size_q);
  assign ub_rd_col_size_valid_in = ub_vld_q;
  assign res_valid               = res_valid_q;
  assign res_data_1              = res1_q;
  assign res_data_2              = res2_q;
  assign busy                    = busy_q;
  assign done                    = done_q;
  assign err_timeout             = err_q;

endmodule

`default_nettype wire
